// File: rtl/tensor_write_sequencer.sv
// Command-driven tensor store sequencer: SET, SET_NTH, FILL and ASSIGN into a
// strided destination through one write port, with a contiguous source read port.
module tensor_write_sequencer #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned RANK     = 4,
    parameter int unsigned IDX_W    = 8,
    parameter int unsigned STRIDE_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [RANK*IDX_W-1:0]      cmd_shape,
    input  logic [RANK*STRIDE_W-1:0]   cmd_stride,
    input  logic [ADDR_W-1:0]          cmd_base,
    input  logic [RANK*IDX_W-1:0]      cmd_index,
    input  logic [ADDR_W-1:0]          cmd_n,
    input  logic [DATA_W-1:0]          cmd_val,
    input  logic [ADDR_W-1:0]          cmd_src_base,
    output logic                       mem_wr_en,
    input  logic                       mem_wr_ready,
    output logic [ADDR_W-1:0]          mem_wr_addr,
    output logic [DATA_W-1:0]          mem_wr_data,
    output logic                       src_rd_en,
    output logic [ADDR_W-1:0]          src_rd_addr,
    input  logic [DATA_W-1:0]          src_rd_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int unsigned MW = IDX_W + STRIDE_W;
    localparam int unsigned PW = RANK * IDX_W + ADDR_W;

    localparam logic [1:0] OP_SET     = 2'd0;
    localparam logic [1:0] OP_SET_NTH = 2'd1;
    localparam logic [1:0] OP_FILL    = 2'd2;
    localparam logic [1:0] OP_ASSIGN  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_WALK, S_WRITE, S_RD, S_CAP, S_DONE
    } state_t;

    state_t                    state;
    logic [1:0]                op_q;
    logic [RANK*IDX_W-1:0]     shape_q;
    logic [RANK*STRIDE_W-1:0]  stride_q;
    logic [ADDR_W-1:0]         base_q;
    logic [ADDR_W-1:0]         n_q;
    logic [DATA_W-1:0]         val_q;
    logic [ADDR_W-1:0]         src_base_q;
    logic [RANK*IDX_W-1:0]     idx_q;
    logic [ADDR_W-1:0]         cnt_q;
    logic [ADDR_W-1:0]         k_q;

    logic [RANK*IDX_W-1:0]     idx_next;
    logic [ADDR_W-1:0]         off_cur;
    logic [ADDR_W-1:0]         off_next;
    logic [PW-1:0]             elem_count;
    logic                      carry;
    logic                      last;
    logic                      shape_zero;
    logic                      idx_oob;
    logic                      check_fail;

    // Odometer step (slice 0 is fastest), offsets of current/next index, element count.
    always_comb begin
        logic [IDX_W-1:0]    sh;
        logic [IDX_W-1:0]    ip;
        logic [IDX_W-1:0]    nx;
        logic [STRIDE_W-1:0] st;
        idx_next   = '0;
        off_cur    = base_q;
        off_next   = base_q;
        elem_count = PW'(1);
        carry      = 1'b1;
        shape_zero = 1'b0;
        idx_oob    = 1'b0;
        for (int p = 0; p < int'(RANK); p++) begin
            sh = shape_q[p*IDX_W +: IDX_W];
            ip = idx_q[p*IDX_W +: IDX_W];
            st = stride_q[p*STRIDE_W +: STRIDE_W];
            nx = ip;
            if (carry) begin
                if (ip == sh - IDX_W'(1)) begin
                    nx = '0;
                end else begin
                    nx    = ip + IDX_W'(1);
                    carry = 1'b0;
                end
            end
            idx_next[p*IDX_W +: IDX_W] = nx;
            off_cur    = off_cur + ADDR_W'(MW'(ip) * MW'(st));
            off_next   = off_next + ADDR_W'(MW'(nx) * MW'(st));
            elem_count = elem_count * PW'(sh);
            if (sh == '0) shape_zero = 1'b1;
            if (ip >= sh) idx_oob = 1'b1;
        end
        last       = carry;
        check_fail = shape_zero
                   || ((op_q == OP_SET) && idx_oob)
                   || ((op_q == OP_SET_NTH) && (PW'(n_q) >= elem_count));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cmd_ready   <= 1'b1;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            src_rd_en   <= 1'b0;
            src_rd_addr <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            op_q        <= '0;
            shape_q     <= '0;
            stride_q    <= '0;
            base_q      <= '0;
            n_q         <= '0;
            val_q       <= '0;
            src_base_q  <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            k_q         <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q       <= cmd_op;
                        shape_q    <= cmd_shape;
                        stride_q   <= cmd_stride;
                        base_q     <= cmd_base;
                        n_q        <= cmd_n;
                        val_q      <= cmd_val;
                        src_base_q <= cmd_src_base;
                        idx_q      <= (cmd_op == OP_SET) ? cmd_index : '0;
                        cnt_q      <= cmd_n;
                        k_q        <= '0;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (check_fail) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else if (op_q == OP_ASSIGN) begin
                        src_rd_en   <= 1'b1;
                        src_rd_addr <= src_base_q;
                        state       <= S_RD;
                    end else if ((op_q == OP_SET_NTH) && (n_q != '0)) begin
                        state <= S_WALK;
                    end else begin
                        mem_wr_en   <= 1'b1;
                        mem_wr_addr <= off_cur;
                        mem_wr_data <= val_q;
                        state       <= S_WRITE;
                    end
                end
                S_WALK: begin
                    idx_q <= idx_next;
                    cnt_q <= cnt_q - ADDR_W'(1);
                    if (cnt_q == ADDR_W'(1)) begin
                        mem_wr_en   <= 1'b1;
                        mem_wr_addr <= off_next;
                        mem_wr_data <= val_q;
                        state       <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (mem_wr_ready) begin
                        if ((op_q == OP_SET) || (op_q == OP_SET_NTH) || last) begin
                            mem_wr_en <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end else if (op_q == OP_FILL) begin
                            idx_q       <= idx_next;
                            mem_wr_addr <= off_next;
                        end else begin
                            mem_wr_en   <= 1'b0;
                            idx_q       <= idx_next;
                            k_q         <= k_q + ADDR_W'(1);
                            src_rd_en   <= 1'b1;
                            src_rd_addr <= src_base_q + k_q + ADDR_W'(1);
                            state       <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    src_rd_en <= 1'b0;
                    state     <= S_CAP;
                end
                // Read data arrives one cycle after the strobe.
                S_CAP: begin
                    mem_wr_en   <= 1'b1;
                    mem_wr_addr <= off_cur;
                    mem_wr_data <= src_rd_data;
                    state       <= S_WRITE;
                end
                S_DONE: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tensor_write_sequencer.sv
// Directed bench for tensor_write_sequencer: logs port activity on the clock edge
// and checks it against hand-computed write/read sequences.
module tb_tensor_write_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [31:0] cmd_shape = '0;
    logic [63:0] cmd_stride = '0;
    logic [15:0] cmd_base = '0;
    logic [31:0] cmd_index = '0;
    logic [15:0] cmd_n = '0;
    logic [31:0] cmd_val = '0;
    logic [15:0] cmd_src_base = '0;
    logic        mem_wr_en;
    logic        mem_wr_ready = 1'b1;
    logic [15:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        src_rd_en;
    logic [15:0] src_rd_addr;
    logic [31:0] src_rd_data = '0;
    logic        busy;
    logic        done;
    logic        err;

    tensor_write_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_shape(cmd_shape), .cmd_stride(cmd_stride), .cmd_base(cmd_base),
        .cmd_index(cmd_index), .cmd_n(cmd_n), .cmd_val(cmd_val),
        .cmd_src_base(cmd_src_base),
        .mem_wr_en(mem_wr_en), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [15:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    logic [15:0] ra[$];
    logic [15:0] stall_a[$];
    logic [31:0] stall_d[$];
    int done_cnt, err_cnt, done_cyc, err_cyc, acc_cyc, first_we, we_hi_cnt;

    // Source memory: data = address + 0x1000, valid one cycle after the strobe.
    always @(posedge clk)
        src_rd_data <= src_rd_en ? ({16'h0, src_rd_addr} + 32'h1000) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (!rst) begin
            if (mem_wr_en && mem_wr_ready) begin
                wa.push_back(mem_wr_addr);
                wd.push_back(mem_wr_data);
                wc.push_back(cyc);
            end
            if (mem_wr_en && !mem_wr_ready) begin
                stall_a.push_back(mem_wr_addr);
                stall_d.push_back(mem_wr_data);
            end
            if (mem_wr_en) begin
                we_hi_cnt++;
                if (first_we < 0) first_we = cyc;
            end
            if (src_rd_en) ra.push_back(src_rd_addr);
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err) begin err_cnt++; err_cyc = cyc; end
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
        end
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete(); wd.delete(); wc.delete(); ra.delete();
        stall_a.delete(); stall_d.delete();
        done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1;
        acc_cyc = -1; first_we = -1; we_hi_cnt = 0;
    endtask

    // Offer one command for one edge, then scramble the fields to prove latching.
    task automatic issue(input logic [1:0] op, input logic [31:0] shape,
                         input logic [63:0] stride, input logic [15:0] base,
                         input logic [31:0] index, input logic [15:0] n,
                         input logic [31:0] val, input logic [15:0] src);
        @(negedge clk);
        cmd_op = op; cmd_shape = shape; cmd_stride = stride; cmd_base = base;
        cmd_index = index; cmd_n = n; cmd_val = val; cmd_src_base = src;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = ~op; cmd_shape = 32'hFFFF_FFFF; cmd_stride = '1; cmd_base = 16'hFFFF;
        cmd_index = '1; cmd_n = 16'hFFFF; cmd_val = 32'hBAD0_BAD0; cmd_src_base = 16'hFFFF;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > 0) break;
            @(negedge clk);
        end
        chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        chk({tag, "_ready_after"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    localparam logic [31:0] SH23   = {8'd1, 8'd1, 8'd2, 8'd3};
    localparam logic [31:0] SH22   = {8'd1, 8'd1, 8'd2, 8'd2};
    localparam logic [63:0] ST31   = {16'd0, 16'd0, 16'd3, 16'd1};
    localparam logic [63:0] ST12   = {16'd0, 16'd0, 16'd1, 16'd2};

    initial begin
        logic [15:0] exp_fill [6];
        logic [15:0] exp_asn_a [4];
        exp_fill  = '{16'd0, 16'd2, 16'd4, 16'd1, 16'd3, 16'd5};
        exp_asn_a = '{16'd0, 16'd2, 16'd1, 16'd3};
        clear_log();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
        chk("rst_src_rd_en", 64'(src_rd_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_wr_addr", 64'(mem_wr_addr), 64'd0);
        chk("rst_wr_data", 64'(mem_wr_data), 64'd0);
        chk("rst_rd_addr", 64'(src_rd_addr), 64'd0);
        rst = 1'b0;

        // SET (0,0,1,2) -> 0x100 + 1*3 + 2 = 0x105
        clear_log();
        issue(2'd0, SH23, ST31, 16'h100, {8'd0, 8'd0, 8'd1, 8'd2}, 16'd0, 32'hAB, 16'd0);
        chk("set_busy", 64'(busy), 64'd1);
        wait_done("set", 50);
        chk("set_nwr", 64'(wa.size()), 64'd1);
        if (wa.size() > 0) begin
            chk("set_addr", 64'(wa[0]), 64'h105);
            chk("set_data", 64'(wd[0]), 64'hAB);
        end
        chk("set_err", 64'(err_cnt), 64'd0);

        // FILL: six back-to-back writes in odometer order
        clear_log();
        issue(2'd2, SH23, ST12, 16'h0, 32'h0, 16'd0, 32'd7, 16'd0);
        wait_done("fill", 50);
        chk("fill_nwr", 64'(wa.size()), 64'd6);
        for (int i = 0; i < 6 && i < wa.size(); i++) begin
            chk($sformatf("fill_addr%0d", i), 64'(wa[i]), 64'(exp_fill[i]));
            chk($sformatf("fill_data%0d", i), 64'(wd[i]), 64'd7);
            chk($sformatf("fill_cyc%0d", i), 64'(wc[i] - wc[0]), 64'(i));
        end
        if (wc.size() == 6) chk("fill_done_cyc", 64'(done_cyc - wc[5]), 64'd1);
        chk("fill_err", 64'(err_cnt), 64'd0);

        // SET_NTH n=4: CHECK + 4 walk cycles, write on the 6th cycle after accept
        clear_log();
        issue(2'd1, SH23, ST31, 16'h0, 32'h0, 16'd4, 32'h55, 16'd0);
        wait_done("nth4", 50);
        chk("nth4_nwr", 64'(wa.size()), 64'd1);
        if (wa.size() > 0) begin
            chk("nth4_addr", 64'(wa[0]), 64'd4);
            chk("nth4_data", 64'(wd[0]), 64'h55);
        end
        chk("nth4_latency", 64'(first_we - acc_cyc), 64'd6);

        // SET_NTH n=6 out of range
        clear_log();
        issue(2'd1, SH23, ST31, 16'h0, 32'h0, 16'd6, 32'h55, 16'd0);
        wait_done("nth6", 50);
        chk("nth6_err", 64'(err_cnt), 64'd1);
        chk("nth6_err_with_done", 64'(err_cyc - done_cyc), 64'd0);
        chk("nth6_no_wr_en", 64'(we_hi_cnt), 64'd0);

        // ASSIGN from contiguous source 0x40
        clear_log();
        issue(2'd3, SH22, ST12, 16'h0, 32'h0, 16'd0, 32'h0, 16'h40);
        wait_done("asn", 60);
        chk("asn_nrd", 64'(ra.size()), 64'd4);
        chk("asn_nwr", 64'(wa.size()), 64'd4);
        for (int i = 0; i < 4 && i < ra.size(); i++)
            chk($sformatf("asn_rd%0d", i), 64'(ra[i]), 64'(16'h40 + 16'(i)));
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            chk($sformatf("asn_waddr%0d", i), 64'(wa[i]), 64'(exp_asn_a[i]));
            chk($sformatf("asn_wdata%0d", i), 64'(wd[i]), 64'(32'h1040 + 32'(i)));
        end
        for (int i = 1; i < 4 && i < wc.size(); i++)
            chk($sformatf("asn_spacing%0d", i), 64'(wc[i] - wc[i-1]), 64'd3);

        // FILL with 3-cycle stall on the 2nd element
        clear_log();
        issue(2'd2, SH23, ST12, 16'h0, 32'h0, 16'd0, 32'd7, 16'd0);
        @(negedge clk);
        @(negedge clk);
        mem_wr_ready = 1'b0;
        repeat (3) @(negedge clk);
        mem_wr_ready = 1'b1;
        wait_done("stall", 50);
        chk("stall_count", 64'(stall_a.size()), 64'd3);
        for (int i = 0; i < stall_a.size(); i++) begin
            chk($sformatf("stall_addr%0d", i), 64'(stall_a[i]), 64'd2);
            chk($sformatf("stall_data%0d", i), 64'(stall_d[i]), 64'd7);
        end
        chk("stall_nwr", 64'(wa.size()), 64'd6);
        for (int i = 0; i < 6 && i < wa.size(); i++)
            chk($sformatf("stall_waddr%0d", i), 64'(wa[i]), 64'(exp_fill[i]));

        // Reset after two FILL writes aborts the command
        clear_log();
        issue(2'd2, SH23, ST12, 16'h0, 32'h0, 16'd0, 32'd7, 16'd0);
        for (int i = 0; i < 20; i++) begin
            if (wa.size() >= 2) break;
            @(negedge clk);
        end
        chk("abort_pre_nwr", 64'(wa.size()), 64'd2);
        rst = 1'b1;
        #1;
        chk("abort_wr_en_in_rst", 64'(mem_wr_en), 64'd0);
        @(negedge clk);
        chk("abort_wr_en_held", 64'(mem_wr_en), 64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_ready", 64'(cmd_ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_nwr", 64'(wa.size()), 64'd2);

        // SET with index 3 on a size-3 dim
        clear_log();
        issue(2'd0, SH23, ST31, 16'h100, {8'd0, 8'd0, 8'd0, 8'd3}, 16'd0, 32'hAB, 16'd0);
        wait_done("oob", 50);
        chk("oob_err", 64'(err_cnt), 64'd1);
        chk("oob_no_wr_en", 64'(we_hi_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
